// File: rtl/mem_req_ctrl_if.sv
// Request/response handshake bundle between a requester (master) and mem_req_ctrl (slave).
// Both directions are valid/ready; the slave holds the response until it is accepted.
interface mem_req_ctrl_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_wr;
   logic [31:0] req_addr;
   logic [3:0]  req_strb;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_rdata;
   logic        resp_err;

   modport master (
      output req_valid, req_wr, req_addr, req_strb, req_wdata, resp_ready,
      input  req_ready, resp_valid, resp_rdata, resp_err
   );

   modport slave (
      input  req_valid, req_wr, req_addr, req_strb, req_wdata, resp_ready,
      output req_ready, resp_valid, resp_rdata, resp_err
   );
endinterface

// File: rtl/mem_req_ctrl.sv
// Single-request load/store controller for ideal_mem; partial stores do read-modify-write.
// Response after 1/2/3 cycles (empty/full-or-load/partial); held until resp_ready. Optional MEM_REQ_CTRL_RANGE_CHECK_EN.
module mem_req_ctrl #(
   parameter int ADDR_WIDTH = 10
) (
   input  logic                  clk,
   input  logic                  rst,
   mem_req_ctrl_if.slave         bus,
   output logic [ADDR_WIDTH-1:0] mem_raddr,
   output logic [ADDR_WIDTH-1:0] mem_waddr,
   output logic                  mem_rden,
   output logic                  mem_wren,
   output logic [31:0]           mem_wdata,
   input  logic [31:0]           mem_rdata
);

   typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

   state_t                state;
   state_t                state_nxt;
   logic [ADDR_WIDTH-3:0] widx_q;
   logic                  wr_q;
   logic [3:0]            strb_q;
   logic [31:0]           wdata_q;
   logic [31:0]           rword_q;
   logic                  accept;
   logic                  range_err;
   logic                  addr_unused;

   assign accept = (state == IDLE) && bus.req_valid;

`ifdef MEM_REQ_CTRL_RANGE_CHECK_EN
   logic err_q;

   assign range_err   = |bus.req_addr[31:ADDR_WIDTH];
   assign addr_unused = ^bus.req_addr[1:0];
`else
   // Upper address bits are dropped, so out-of-range addresses alias into the array.
   assign range_err   = 1'b0;
   assign addr_unused = ^{bus.req_addr[31:ADDR_WIDTH], bus.req_addr[1:0]};
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (bus.req_valid) begin
               if (range_err)                  state_nxt = RESP;
               else if (!bus.req_wr)           state_nxt = READ;
               else if (bus.req_strb == 4'hF)  state_nxt = WRITE;
               else if (bus.req_strb == 4'h0)  state_nxt = RESP;
               else                            state_nxt = READ;
            end
         end
         READ:    state_nxt = wr_q ? WRITE : RESP;
         WRITE:   state_nxt = RESP;
         RESP:    if (bus.resp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         widx_q  <= '0;
         wr_q    <= 1'b0;
         strb_q  <= 4'h0;
         wdata_q <= '0;
         rword_q <= '0;
`ifdef MEM_REQ_CTRL_RANGE_CHECK_EN
         err_q   <= 1'b0;
`endif
      end else begin
         if (accept) begin
            widx_q  <= bus.req_addr[ADDR_WIDTH-1:2];
            wr_q    <= bus.req_wr;
            strb_q  <= bus.req_strb;
            wdata_q <= bus.req_wdata;
            rword_q <= '0;
`ifdef MEM_REQ_CTRL_RANGE_CHECK_EN
            err_q   <= range_err;
`endif
         end
         if (state == READ) begin
            rword_q <= mem_rdata;
         end
      end
   end

   always_comb begin
      bus.req_ready  = (state == IDLE) && !rst;
      mem_rden       = (state == READ);
      mem_wren       = (state == WRITE) && !rst;
      bus.resp_valid = (state == RESP);
      bus.resp_rdata = ((state == RESP) && !wr_q) ? rword_q : 32'h0;
`ifdef MEM_REQ_CTRL_RANGE_CHECK_EN
      bus.resp_err   = (state == RESP) && err_q;
`else
      bus.resp_err   = 1'b0;
`endif
   end

   // Unstrobed lanes keep the word fetched in READ.
   always_comb begin
      mem_wdata = 32'h0;
      for (int i = 0; i < 4; i++) begin
         mem_wdata[8*i +: 8] = strb_q[i] ? wdata_q[8*i +: 8] : rword_q[8*i +: 8];
      end
   end

   assign mem_raddr = {2'b00, widx_q};
   assign mem_waddr = {2'b00, widx_q};

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Directed bench for mem_req_ctrl against a behavioural ideal_mem (combinational read, clocked write).
// Outputs are sampled on the falling edge; cycle N+k is the k-th cycle after the acceptance edge.
module tb_mem_req_ctrl;
   localparam int AW = 10;

   logic          clk = 1'b0;
   logic          rst;
   logic [AW-1:0] mem_raddr, mem_waddr;
   logic          mem_rden, mem_wren;
   logic [31:0]   mem_wdata, mem_rdata;

   mem_req_ctrl_if bus ();

   mem_req_ctrl #(.ADDR_WIDTH(AW)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .mem_raddr (mem_raddr),
      .mem_waddr (mem_waddr),
      .mem_rden  (mem_rden),
      .mem_wren  (mem_wren),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata)
   );

   always #5 clk = ~clk;

   logic [31:0]   mem [0:(1<<AW)-1];
   logic          bd_we = 1'b0;
   logic [AW-1:0] bd_idx = '0;
   logic [31:0]   bd_dat = '0;
   int            wr_commits = 0;

   assign mem_rdata = mem[mem_raddr];

   always @(posedge clk) begin
      if (bd_we)         mem[bd_idx]    <= bd_dat;
      else if (mem_wren) mem[mem_waddr] <= mem_wdata;
   end

   always @(posedge clk) if (mem_wren) wr_commits <= wr_commits + 1;

   int          n_vec = 0;
   int          n_err = 0;
   int          lat, wren_n, wren_at, rden_n, commits0;
   logic [31:0] wren_dat, rdata_got, wren_idx;
   logic        err_got;
   logic        range_chk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Issue one request at the current falling edge, track the memory strobes, then retire the response.
   task automatic txn(input logic wr, input logic [31:0] addr, input logic [3:0] strb,
                      input logic [31:0] wdata, input int hold);
      bus.req_valid  = 1'b1;
      bus.req_wr     = wr;
      bus.req_addr   = addr;
      bus.req_strb   = strb;
      bus.req_wdata  = wdata;
      bus.resp_ready = (hold == 0);
      #1;
      chk("req_ready_at_issue", {31'b0, bus.req_ready}, 32'd1);
      @(posedge clk);
      @(negedge clk);
      bus.req_valid = 1'b0;
      bus.req_wr    = ~wr;
      bus.req_addr  = 32'hFFFF_FFFC;
      bus.req_strb  = ~strb;
      bus.req_wdata = 32'h5A5A_5A5A;
      lat = 1; wren_n = 0; wren_at = 0; rden_n = 0; wren_dat = '0; wren_idx = '0;
      while (!bus.resp_valid && lat < 8) begin
         if (mem_wren) begin
            wren_n++;
            wren_at  = lat;
            wren_dat = mem_wdata;
            wren_idx = {22'b0, mem_waddr};
         end
         if (mem_rden) rden_n++;
         @(negedge clk);
         lat++;
      end
      rdata_got = bus.resp_rdata;
      err_got   = bus.resp_err;
      for (int i = 0; i < hold; i++) begin
         chk("hold_resp_valid", {31'b0, bus.resp_valid}, 32'd1);
         chk("hold_resp_rdata", bus.resp_rdata, rdata_got);
         chk("hold_req_ready",  {31'b0, bus.req_ready}, 32'd0);
         @(negedge clk);
      end
      bus.resp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("resp_valid_after_hs", {31'b0, bus.resp_valid}, 32'd0);
      chk("req_ready_after_hs",  {31'b0, bus.req_ready},  32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired observed=running required=finished");
      $fatal(1, "timeout");
   end

   initial begin
`ifdef MEM_REQ_CTRL_RANGE_CHECK_EN
      range_chk = 1'b1;
`else
      range_chk = 1'b0;
`endif
      rst = 1'b1;
      bus.req_valid = 1'b0; bus.req_wr = 1'b0; bus.req_addr = '0;
      bus.req_strb = '0; bus.req_wdata = '0; bus.resp_ready = 1'b1;

      // Reset with backdoor preload of the words the sequence touches.
      @(negedge clk); bd_we = 1'b1; bd_idx = 10'h08A; bd_dat = 32'h0000_0002;
      @(negedge clk); bd_idx = 10'h040; bd_dat = 32'h0;
      @(negedge clk); bd_idx = 10'h000; bd_dat = 32'hDEAD_BEEF;
      @(negedge clk); bd_we = 1'b0;
      chk("rst_req_ready",  {31'b0, bus.req_ready},  32'd0);
      chk("rst_mem_wren",   {31'b0, mem_wren},       32'd0);
      chk("rst_resp_valid", {31'b0, bus.resp_valid}, 32'd0);
      chk("rst_resp_rdata", bus.resp_rdata,          32'd0);
      chk("rst_resp_err",   {31'b0, bus.resp_err},   32'd0);
      @(posedge clk);
      @(negedge clk); rst = 1'b0;
      #1 chk("ready_after_rst", {31'b0, bus.req_ready}, 32'd1);

      // Load 0x228
      txn(1'b0, 32'h228, 4'h0, 32'h0, 0);
      chk("ld228_lat",   lat, 2);
      chk("ld228_rdata", rdata_got, 32'h0000_0002);
      chk("ld228_err",   {31'b0, err_got}, 32'd0);
      chk("ld228_rden",  rden_n, 1);
      chk("ld228_wren",  wren_n, 0);

      // Partial store lane 1 to 0x228
      txn(1'b1, 32'h228, 4'b0010, 32'h0000_AB00, 0);
      chk("pst_lat",     lat, 3);
      chk("pst_wren_n",  wren_n, 1);
      chk("pst_wren_at", wren_at, 2);
      chk("pst_wdata",   wren_dat, 32'h0000_AB02);
      chk("pst_waddr",   wren_idx, 32'h8A);
      chk("pst_rdata",   rdata_got, 32'h0);
      txn(1'b0, 32'h228, 4'h0, 32'h0, 0);
      chk("pst_readback", rdata_got, 32'h0000_AB02);

      // Full store to 0x100
      txn(1'b1, 32'h100, 4'hF, 32'h1234_5678, 0);
      chk("fst_lat",     lat, 2);
      chk("fst_wren_n",  wren_n, 1);
      chk("fst_wren_at", wren_at, 1);
      chk("fst_rden",    rden_n, 0);
      txn(1'b0, 32'h100, 4'h0, 32'h0, 0);
      chk("fst_readback", rdata_got, 32'h1234_5678);

      // Empty-strobe store: response only, memory untouched
      commits0 = wr_commits;
      txn(1'b1, 32'h228, 4'h0, 32'hFFFF_FFFF, 0);
      chk("est_lat",    lat, 1);
      chk("est_wren",   wr_commits - commits0, 0);
      chk("est_rden",   rden_n, 0);
      chk("est_rdata",  rdata_got, 32'h0);
      txn(1'b0, 32'h228, 4'h0, 32'h0, 0);
      chk("est_readback", rdata_got, 32'h0000_AB02);

      // Response backpressure for 3 cycles
      txn(1'b0, 32'h100, 4'h0, 32'h0, 3);
      chk("bp_lat",   lat, 2);
      chk("bp_rdata", rdata_got, 32'h1234_5678);

      // Store beyond the array: error with range check, alias to word 0 without
      commits0 = wr_commits;
      txn(1'b1, 32'h400, 4'hF, 32'hCAFE_F00D, 0);
      chk("oor_lat",     lat, range_chk ? 32'd1 : 32'd2);
      chk("oor_err",     {31'b0, err_got}, {31'b0, range_chk});
      chk("oor_commits", wr_commits - commits0, range_chk ? 32'd0 : 32'd1);
      chk("oor_rdata",   rdata_got, 32'h0);
      if (!range_chk) chk("oor_waddr", wren_idx, 32'h0);
      txn(1'b0, 32'h000, 4'h0, 32'h0, 0);
      chk("oor_readback", rdata_got, range_chk ? 32'hDEAD_BEEF : 32'hCAFE_F00D);

      // Reset landing in the WRITE cycle of a partial store
      commits0 = wr_commits;
      bus.req_valid = 1'b1; bus.req_wr = 1'b1; bus.req_addr = 32'h100;
      bus.req_strb = 4'b0001; bus.req_wdata = 32'h0000_00FF; bus.resp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk); bus.req_valid = 1'b0;
      chk("rstw_read_cycle", {31'b0, mem_rden}, 32'd1);
      @(posedge clk);
      #1 chk("rstw_in_write", {31'b0, mem_wren}, 32'd1);
      rst = 1'b1;
      #1 chk("rstw_wren_gated", {31'b0, mem_wren}, 32'd0);
      chk("rstw_ready_gated", {31'b0, bus.req_ready}, 32'd0);
      @(posedge clk);
      @(negedge clk); rst = 1'b0;
      chk("rstw_no_resp", {31'b0, bus.resp_valid}, 32'd0);
      #1 chk("rstw_ready", {31'b0, bus.req_ready}, 32'd1);
      chk("rstw_commits", wr_commits - commits0, 0);
      txn(1'b0, 32'h100, 4'h0, 32'h0, 0);
      chk("rstw_readback", rdata_got, 32'h1234_5678);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
